// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier, SoC reset sequencer and per-channel clock-enable dividers.
// Optional macro PLL_RESET_SEQ_LOCK_COUNT_EN enables the saturating lock-loss counter.
module pll_reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 256,
    parameter int RESET_HOLD  = 1024
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        pll_locked,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_value,
    input  logic [NUM_CH-1:0]           ch_enable,
    output logic                        sys_reset,
    output logic                        ready,
    output logic [NUM_CH-1:0]           clock_en,
    output logic [7:0]                  lock_lost_count,
    output logic [1:0]                  dbg_state
);

    localparam int STABLE_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int HOLD_W   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [STABLE_W-1:0]     r_stable_cnt;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic                    r_sys_reset;
    logic                    r_ready;
    logic                    w_lock_s;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // The cycle in which WAIT_LOCK first sees lock_s already counts as one stable cycle.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state      <= ST_WAIT_LOCK;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_stable_cnt <= '0;
                    r_hold_cnt   <= '0;
                    if (w_lock_s) begin
                        if (LOCK_STABLE == 1) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state      <= ST_STABILIZE;
                            r_stable_cnt <= STABLE_W'(1);
                        end
                    end
                end
                ST_STABILIZE: begin
                    if (!w_lock_s) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_stable_cnt <= '0;
                    end else if (r_stable_cnt == STABLE_LAST) begin
                        r_state      <= ST_HOLD;
                        r_stable_cnt <= '0;
                        r_hold_cnt   <= '0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= ST_RUN;
                        r_hold_cnt  <= '0;
                        r_sys_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_sys_reset <= 1'b1;
                        r_ready     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_WAIT_LOCK;
                    r_sys_reset <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign dbg_state = r_state;

`ifdef PLL_RESET_SEQ_LOCK_COUNT_EN
    logic [7:0] r_lock_lost;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_lock_lost <= 8'd0;
        end else if (r_state == ST_RUN && !w_lock_s && r_lock_lost != 8'hFF) begin
            r_lock_lost <= r_lock_lost + 8'd1;
        end
    end

    assign lock_lost_count = r_lock_lost;
`else
    assign lock_lost_count = 8'd0;
`endif

    // Strobes gate on the registered ready so they drop in the same cycle ready falls.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_WIDTH-1:0] r_cnt;
            logic [DIV_WIDTH-1:0] w_div;
            logic                 w_strobe;

            assign w_div    = div_value[gi*DIV_WIDTH +: DIV_WIDTH];
            assign w_strobe = r_ready && ch_enable[gi] && (r_cnt >= w_div);

            always_ff @(posedge clock_in or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!r_ready || !w_lock_s || !ch_enable[gi] || w_strobe) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DIV_WIDTH'(1);
                end
            end

            assign clock_en[gi] = w_strobe;
        end
    endgenerate

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised clock/reset manager; sits directly downstream of the board PLL wrapper, in the PLL output clock domain.
- Synchronises the asynchronous PLL lock flag and qualifies it for a stable period.
- Generates the SoC-wide synchronous reset with a programmable hold time.
- Provides NUM_CH independent programmable clock-enable strobes (CPU, VGA, UART, RAM, ...), so the rest of the SoC runs single-clock.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..8)
- DIV_WIDTH, 16, width of each channel divisor
- SYNC_STAGES, 2, flops in the lock synchroniser (>=2)
- LOCK_STABLE, 256, consecutive synced-lock cycles required before reset hold begins (>=1)
- RESET_HOLD, 1024, cycles sys_reset stays high after lock is qualified (>=1)

Ports:
- clock_in  input  1  PLL output clock; only clock of the block
- reset  input  1  asynchronous, active-high reset
- pll_locked  input  1  raw PLL lock flag, asynchronous to clock_in
- div_value  input  NUM_CH*DIV_WIDTH  channel i divisor at bits [i*DIV_WIDTH +: DIV_WIDTH]
- ch_enable  input  NUM_CH  per-channel run enable
- sys_reset  output  1  synchronous active-high reset to the SoC
- ready  output  1  high in RUN state
- clock_en  output  NUM_CH  per-channel one-cycle enable strobes
- lock_lost_count  output  8  saturating count of lock losses seen in RUN

Behaviour:
- On reset assertion, asynchronously:
  - sys_reset=1, ready=0, clock_en=0, lock_lost_count=0
  - synchroniser cleared to 0, all counters 0, state=WAIT_LOCK
- lock_s is the output of the SYNC_STAGES-deep synchroniser; it is the only use of pll_locked.
- FSM states: WAIT_LOCK, STABILIZE, HOLD, RUN.
- WAIT_LOCK:
  - sys_reset=1, stable counter=0.
  - lock_s=1 -> STABILIZE.
- STABILIZE:
  - sys_reset=1; stable counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK, counter cleared.
  - Counter reaches LOCK_STABLE-1 with lock_s=1 -> HOLD.
- HOLD:
  - sys_reset=1; hold counter increments.
  - lock_s=0 -> WAIT_LOCK.
  - Counter reaches RESET_HOLD-1 -> RUN.
- RUN:
  - sys_reset=0, ready=1.
  - lock_s=0 -> WAIT_LOCK.
  - lock_lost_count increments by 1 on that transition, saturating at 255.
- Latency from pll_locked rising, with a clean lock: ready and sys_reset deassertion occur exactly SYNC_STAGES+LOCK_STABLE+RESET_HOLD cycles later.
- Lock loss in RUN: sys_reset reasserts exactly SYNC_STAGES+1 cycles after pll_locked falls.
- A lock glitch shorter than LOCK_STABLE during STABILIZE restarts qualification from zero.
- sys_reset and ready are registered outputs, driven directly from state.
- Channel dividers, per channel i:
  - DIV_WIDTH-bit counter cnt[i]; cnt[i] is 0 outside RUN and while ch_enable[i]=0.
  - In RUN with ch_enable[i]=1: clock_en[i] = (cnt[i] >= div[i]).
  - When clock_en[i] is high, cnt[i] returns to 0; otherwise it increments.
  - div=N therefore yields one strobe every N+1 cycles, first strobe N cycles after the first RUN cycle (or after ch_enable rises).
  - div=0: clock_en[i] constant 1 while in RUN and enabled.
  - div lowered below the current cnt: strobe on the next cycle, then the new period applies; no counter wrap-through.
  - div=all-ones: period 2^DIV_WIDTH, no overflow.
- clock_en is forced to 0 in every non-RUN state and in the same cycle ready falls.

Optional Feature:
- Macro: PLL_RESET_SEQ_LOCK_COUNT_EN.
- Defined: lock_lost_count operates as described.
- Undefined: counter logic is omitted, and lock_lost_count is tied to 8'd0.

Test Plan:
Bench parameters: NUM_CH=2, DIV_WIDTH=4, SYNC_STAGES=2, LOCK_STABLE=4, RESET_HOLD=8.
- Reset release, then pll_locked rises at cycle 0 -> sys_reset falls and ready rises at cycle 14; clock_en=0 before that.
- Lock glitch: pll_locked high 3 cycles, low 2, high again -> state returns to WAIT_LOCK; ready rises 14 cycles after the second rising edge.
- div0=0, div1=3, both enabled in RUN -> clock_en[0] high every cycle; clock_en[1] at RUN cycles 3, 7, 11.
- div1=9, then changed to 2 when cnt1=6 -> strobe the next cycle, then every 3 cycles.
- pll_locked dropped in RUN -> sys_reset=1 and clock_en=0 three cycles later; lock_lost_count 0->1. 300 losses -> saturates at 255 (macro defined); reads 0 throughout with the macro undefined.
- reset asserted mid-HOLD -> all outputs return to reset values immediately (asynchronously); with pll_locked held high, sequence restarts and ready rises 14 cycles after reset release.
